sub: RTL and testbench

//   Registered 4-bit unsigned subtractor with borrow-in and borrow-out.

---
 rtl/sub_pkg.sv | 5 +
 rtl/sub_full_sub.sv | 11 +
 rtl/sub.sv | 38 +++
 tb/tb_sub.sv | 84 ++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// sub_pkg: shared width constant and word type for the borrow-chained subtractor
package sub_pkg;
  localparam int SUB_WIDTH = 4;
  typedef logic [SUB_WIDTH-1:0] sub_word_t;
endpackage

// File: rtl/sub_full_sub.sv
// full_sub: 1-bit combinational full subtractor; a - b - bin gives difference d and borrow out bout
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub.sv
// sub: registered ripple-borrow subtractor {b4,D} <= A - B - b_in; clk, sync active-low rst_n, inputs b_in/A/B, outputs D/b4
module sub
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             b4
);
  logic [WIDTH:0] bw;
  logic [WIDTH-1:0] diff, d_d, d_q;
  logic b4_d, b4_q;
  assign bw[0] = b_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_sub u_fs (
      .a   (A[i]),
      .b   (B[i]),
      .bin (bw[i]),
      .d   (diff[i]),
      .bout(bw[i+1])
    );
  end
  always_comb begin
    d_d = rst_n ? diff : '0;
    b4_d = rst_n ? bw[WIDTH] : 1'b0;
  end
  always_ff @(posedge clk) begin
    d_q <= d_d;
    b4_q <= b4_d;
  end
  assign D = d_q;
  assign b4 = b4_q;
endmodule

// File: tb/tb_sub.sv
// tb_sub: directed self-checking bench for sub, including exhaustive sweep and a two-stage chain
module tb_sub;
  import sub_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_in = 1'b0;
  sub_word_t A = '0, B = '0, D;
  logic b4;
  logic [7:0] ca = '0, cb = '0;
  logic [3:0] lo_d, hi_d;
  logic lo_b4, hi_b4;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  sub u_dut (.clk(clk), .rst_n(rst_n), .b_in(b_in), .A(A), .B(B), .D(D), .b4(b4));
  sub u_lo (.clk(clk), .rst_n(rst_n), .b_in(1'b0), .A(ca[3:0]), .B(cb[3:0]), .D(lo_d), .b4(lo_b4));
  sub u_hi (.clk(clk), .rst_n(rst_n), .b_in(lo_b4), .A(ca[7:4]), .B(cb[7:4]), .D(hi_d), .b4(hi_b4));
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic bi, input logic rn);
    @(negedge clk);
    A = a;
    B = b;
    b_in = bi;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed {b4,D}=%h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [4:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic bi);
    return ({1'b0, a} - {1'b0, b} - {4'b0, bi});
  endfunction
  initial begin
    logic [3:0] ra, rb;
    logic rbi;
    logic [8:0] v;
    step(4'd7, 4'd2, 1'b1, 1'b0);
    chk("reset1", {b4, D}, 5'h00);
    step(4'd7, 4'd2, 1'b1, 1'b0);
    chk("reset2", {b4, D}, 5'h00);
    step(4'd9, 4'd3, 1'b0, 1'b1);
    chk("9-3", {b4, D}, 5'h06);
    step(4'd3, 4'd9, 1'b0, 1'b1);
    chk("3-9", {b4, D}, 5'h1A);
    step(4'd5, 4'd5, 1'b1, 1'b1);
    chk("eq_bin1", {b4, D}, 5'h1F);
    step(4'd0, 4'd15, 1'b1, 1'b1);
    chk("wrap", {b4, D}, 5'h10);
    step(4'd15, 4'd0, 1'b0, 1'b1);
    chk("max", {b4, D}, 5'h0F);
    step(4'd6, 4'd6, 1'b0, 1'b1);
    chk("eq_bin0", {b4, D}, 5'h00);
    for (int i = 0; i < 512; i++) begin
      v = i[8:0];
      step(v[4:1], v[8:5], v[0], 1'b1);
      chk("sweep", {b4, D}, ref_sub(v[4:1], v[8:5], v[0]));
    end
    for (int i = 0; i < 6; i++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rbi = 1'($urandom_range(1));
      step(ra, rb, rbi, 1'b1);
      chk("stream", {b4, D}, ref_sub(ra, rb, rbi));
    end
    step(4'd2, 4'd9, 1'b1, 1'b0);
    chk("mid_reset", {b4, D}, 5'h00);
    step(4'd12, 4'd4, 1'b1, 1'b1);
    chk("resume", {b4, D}, 5'h07);
    @(negedge clk);
    ca = 8'h30;
    cb = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    chk("chain_lo", {lo_b4, lo_d}, 5'h1F);
    chk("chain_hi", {hi_b4, hi_d}, 5'h02);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
